// File: rtl/dds_sweep_controller_if.sv
// Control/status bundle between a sweep sequencer (master) and dds_sweep_controller (slave).
interface dds_sweep_controller_if #(
    parameter int DWELL_W = 24
);
    logic               start;
    logic               abort;
    logic               loop;
    logic [31:0]        start_word;
    logic [31:0]        stop_word;
    logic [31:0]        step;
    logic [DWELL_W-1:0] dwell;
    logic [31:0]        m;
    logic               set;
    logic               en;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, loop, start_word, stop_word, step, dwell,
        input  m, set, en, busy, done
    );

    modport slave (
        input  start, abort, loop, start_word, stop_word, step, dwell,
        output m, set, en, busy, done
    );
endinterface

// File: rtl/dds_sweep_controller.sv
// Steps a DDS tuning word from start_word to stop_word, holding each point for dwell cycles.
// Define SWEEP_BIDIR_EN to build the triangle (up then down) sweep variant.
module dds_sweep_controller #(
    parameter int DWELL_W = 24
) (
    input logic                  clk,
    input logic                  rst_n,
    dds_sweep_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SET,
        S_DWELL,
        S_STEP,
        S_FINISH
    } state_t;

    state_t             state, nxt;
    logic [31:0]        m_q, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r, dcnt, dwell_last;
    logic [32:0]        up_sum;
    logic               up_end, fin;
    logic               set_q, busy_q, done_q;
`ifdef SWEEP_BIDIR_EN
    logic [31:0]        start_r;
    logic               down_q, turn;
`endif

    always_comb begin
        up_sum     = {1'b0, m_q} + {1'b0, step_r};
        // Zero step or an empty/inverted range ends the sweep after the first point
        up_end     = (step_r == '0) || (m_q >= stop_r);
        dwell_last = (dwell_r == '0) ? '0 : dwell_r - DWELL_W'(1);
`ifdef SWEEP_BIDIR_EN
        turn = !down_q && up_end && (step_r != '0) && (start_r < stop_r);
        fin  = down_q ? (m_q <= start_r) : (up_end && !turn);
`else
        fin  = up_end;
`endif
        nxt = state;
        case (state)
            S_IDLE:   if (bus.start) nxt = S_LOAD;
            S_LOAD:   nxt = S_SET;
            S_SET:    nxt = S_DWELL;
            S_DWELL:  if (dcnt == dwell_last) nxt = S_STEP;
            S_STEP:   nxt = fin ? S_FINISH : S_SET;
            S_FINISH: nxt = bus.loop ? S_LOAD : S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        if (bus.abort) nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            m_q     <= '0;
            stop_r  <= '0;
            step_r  <= '0;
            dwell_r <= '0;
            dcnt    <= '0;
            set_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            start_r <= '0;
            down_q  <= 1'b0;
`endif
        end else begin
            state  <= nxt;
            set_q  <= (nxt == S_SET);
            busy_q <= (nxt != S_IDLE);
            done_q <= (state == S_FINISH) && !bus.loop && !bus.abort;
            // Datapath is frozen on abort so m keeps the last point
            if (!bus.abort) begin
                case (state)
                    S_LOAD: begin
                        m_q     <= bus.start_word;
                        stop_r  <= bus.stop_word;
                        step_r  <= bus.step;
                        dwell_r <= bus.dwell;
`ifdef SWEEP_BIDIR_EN
                        start_r <= bus.start_word;
                        down_q  <= 1'b0;
`endif
                    end
                    S_SET:   dcnt <= '0;
                    S_DWELL: dcnt <= dcnt + DWELL_W'(1);
                    S_STEP: begin
`ifdef SWEEP_BIDIR_EN
                        if (down_q || turn) begin
                            down_q <= 1'b1;
                            m_q    <= (m_q - start_r <= step_r) ? start_r : m_q - step_r;
                        end else
`endif
                        if (!up_end)
                            m_q <= (up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[31:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.m    = m_q;
    assign bus.set  = set_q;
    assign bus.en   = busy_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Randomised and directed checks of dds_sweep_controller against a point-list reference model.
module tb_dds_sweep_controller;

    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    longint unsigned exp_q[$];

    always #5 clk = ~clk;

    dds_sweep_controller_if #(.DWELL_W(DW)) bus ();

    dds_sweep_controller #(.DWELL_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected list of tuning words visited by one sweep pass
    task automatic build(input longint unsigned s, input longint unsigned e, input longint unsigned st);
        longint unsigned v;
        exp_q.delete();
        v = s;
        exp_q.push_back(v);
        if (st != 0 && s < e) begin
            while (v < e) begin
                v = (v + st >= e) ? e : v + st;
                exp_q.push_back(v);
            end
`ifdef SWEEP_BIDIR_EN
            while (v > s) begin
                v = (v - s <= st) ? s : v - st;
                exp_q.push_back(v);
            end
`endif
        end
    endtask

    task automatic sweep(input logic [31:0] sw, input logic [31:0] ew, input logic [31:0] st,
                         input logic [DW-1:0] dw, input bit poke_start);
        int  cyc, idx, d, n;
        bit  got_done, prev_busy;
        build(sw, ew, st);
        n = exp_q.size();
        d = (dw == 0) ? 1 : int'(dw);
        @(negedge clk);
        bus.start_word = sw;
        bus.stop_word  = ew;
        bus.step       = st;
        bus.dwell      = dw;
        bus.loop       = 1'b0;
        bus.start      = 1'b1;
        cyc = 0; idx = 0; got_done = 0; prev_busy = 0;
        while (!got_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == 2) begin
                bus.start_word = $urandom;
                bus.stop_word  = $urandom;
                bus.step       = $urandom;
                bus.dwell      = DW'($urandom_range(0, 7));
            end
            if (poke_start) bus.start = (cyc == 4);
            if (bus.set) begin
                if (idx < n) check("set_m", bus.m, exp_q[idx]);
                else check("set_count", idx + 1, n);
                check("set_time", cyc, 2 + idx * (d + 2));
                check("en_busy", {bus.en, bus.busy}, 2'b11);
                idx++;
            end
            if (bus.done) begin
                got_done = 1;
                check("done_time", cyc, 2 + (n - 1) * (d + 2) + d + 3);
                check("points", idx, n);
                check("busy_fall", {prev_busy, bus.busy}, 2'b10);
            end
            prev_busy = bus.busy;
        end
        check("done_seen", got_done, 1);
        @(negedge clk);
        check("done_width", bus.done, 0);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.loop = 0;
        bus.start_word = 0; bus.stop_word = 0; bus.step = 0; bus.dwell = 0;
        #12;
        check("rst_m", bus.m, 0);
        check("rst_outs", {bus.set, bus.en, bus.busy, bus.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(100, 130, 10, 3, 0);
        sweep(100, 125, 10, 1, 0);
        sweep(500, 900, 0, 2, 0);
        sweep(700, 300, 50, 0, 0);
        sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        sweep(0, 30, 10, 2, 1);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] s, st;
            s  = $urandom;
            st = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(200, 1000));
            sweep(s, s + 32'($urandom_range(0, 8000)), st, DW'($urandom_range(0, 5)), 0);
        end

        // abort during the third dwell
        @(negedge clk);
        bus.start_word = 0; bus.stop_word = 40; bus.step = 10; bus.dwell = 4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            int sets = 0, t = 0;
            while (sets < 3 && t < 200) begin
                @(negedge clk);
                t++;
                if (bus.set) sets++;
            end
            check("abort_reach", sets, 3);
        end
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_m", bus.m, 20);
        check("abort_outs", {bus.set, bus.en, bus.busy, bus.done}, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_quiet", {bus.busy, bus.done}, 0);
        end

        // abort together with start in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        check("abort_start", bus.busy, 0);

        // looping sweep repeats without done
        bus.start_word = 100; bus.stop_word = 120; bus.step = 10; bus.dwell = 1;
        bus.loop = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        build(100, 120, 10);
        begin
            int sets = 0, t = 0, n;
            n = exp_q.size();
            while (sets < 2 * n && t < 500) begin
                @(negedge clk);
                t++;
                check("loop_no_done", bus.done, 0);
                if (bus.set) begin
                    check("loop_m", bus.m, exp_q[sets % n]);
                    sets++;
                end
            end
            check("loop_sets", sets, 2 * n);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.loop = 1'b0;
        check("loop_abort", bus.busy, 0);

        // asynchronous reset mid-dwell
        bus.start_word = 1000; bus.stop_word = 2000; bus.step = 100; bus.dwell = 6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m", bus.m, 0);
        check("arst_outs", {bus.set, bus.en, bus.busy, bus.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done", bus.done, 0);
        sweep(1000, 1300, 100, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_controller.md
DDS_SWEEP_CONTROLLER -- requirements
Module: dds_sweep_controller

Interface
REQ-001 SHALL have parameter DWELL_W, default 24: width of the dwell counter and dwell input.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a sweep; honoured only in IDLE.
REQ-005 SHALL have port abort, input, 1: level; forces return to IDLE from any state.
REQ-006 SHALL have port loop, input, 1: when 1 at end of sweep, restart from start_word instead of finishing.
REQ-007 SHALL have port start_word, input, 32: first tuning word.
REQ-008 SHALL have port stop_word, input, 32: last tuning word.
REQ-009 SHALL have port step, input, 32: tuning-word increment per point.
REQ-010 SHALL have port dwell, input, DWELL_W: clock cycles held per point.
REQ-011 SHALL have port m, output, 32: tuning word to the DDS, registered.
REQ-012 SHALL have port set, output, 1: one-cycle strobe; DDS loads m on it.
REQ-013 SHALL have port en, output, 1: DDS output enable; 1 whenever busy.
REQ-014 SHALL have port busy, output, 1: 1 in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a non-looping sweep completes.

Function
REQ-016 SHALL implement states IDLE, LOAD, SET, DWELL, STEP, FINISH.
REQ-017 IDLE: start=1 SHALL go to LOAD next cycle; start in any other state SHALL be ignored.
REQ-018 LOAD: SHALL latch start_word, stop_word, step, dwell into internal registers, set m<=start_word, go to SET; later input changes SHALL NOT affect the running sweep.
REQ-019 SET: set SHALL be 1 for exactly this one cycle with m stable; go to DWELL.
REQ-020 DWELL: SHALL stay max(dwell,1) cycles (dwell=0 treated as 1), then go to STEP.
REQ-021 STEP: if m == stop, SHALL go to FINISH; else next m = stop if m+step (33-bit unsigned sum) >= stop, else m+step; then go to SET.
REQ-022 Latency: first set pulse SHALL occur 2 cycles after start is sampled; consecutive set pulses SHALL be max(dwell,1)+2 cycles apart.
REQ-023 step=0 or start_word >= stop_word SHALL produce a single point at start_word followed by FINISH.
REQ-024 FINISH: loop=1 SHALL go to LOAD (re-latching inputs) without a done pulse; loop=0 SHALL pulse done, go to IDLE.
REQ-025 abort=1 in any state SHALL go to IDLE next cycle with set=0, done=0, en=0; m SHALL hold its last value.
REQ-026 abort and start asserted together in IDLE SHALL leave the block in IDLE.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, m=0, set=0, en=0, busy=0, done=0, dwell counter=0.
REQ-028 Reset mid-sweep SHALL discard the sweep; no done pulse on release.

Configuration
REQ-029 Macro SWEEP_BIDIR_EN SHALL select triangle sweep.
REQ-030 With SWEEP_BIDIR_EN defined: after the stop_word point, SHALL step down by step (saturating at start_word) through the same SET/DWELL timing, then FINISH after the start_word point; the stop_word point SHALL NOT be repeated.
REQ-031 Without SWEEP_BIDIR_EN: sawtooth only, per REQ-021; no down-counting logic present.

Verification
REQ-032 start_word=100, stop_word=130, step=10, dwell=3, loop=0 -> set pulses with m=100,110,120,130, 5 cycles apart; done 1 pulse; busy falls with done.
REQ-033 start_word=100, stop_word=125, step=10, dwell=1 -> m=100,110,120,125 (clamped), then done.
REQ-034 step=0, start_word=500 -> exactly one set with m=500, then done.
REQ-035 Sweep 0->40 step 10, abort during third DWELL -> IDLE next cycle, en=0, m=20, no done.
REQ-036 rst_n low mid-DWELL -> outputs at reset values asynchronously; start after release restarts from start_word.
REQ-037 SWEEP_BIDIR_EN defined, 0->30 step 10, dwell=2 -> m=0,10,20,30,20,10,0, then done; loop=1 -> repeats without done.
